// File: rtl/beat_track_memory.sv
// rtl/beat_track_memory.sv - two-track beat recorder/looper with merged live+playback note output
module beat_track_memory #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 256,
    parameter int TICK_DIV = 50000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [WIDTH-1:0]         keys_in,
    input  logic                     ramARecord,
    input  logic                     ramBRecord,
    input  logic                     loadAFromRam,
    input  logic                     loadBFromRam,
    output logic [WIDTH-1:0]         playA,
    output logic [WIDTH-1:0]         playB,
    output logic [WIDTH-1:0]         notes_out,
    output logic [$clog2(DEPTH):0]   lenA,
    output logic [$clog2(DEPTH):0]   lenB,
    output logic                     fullA,
    output logic                     fullB,
    output logic                     tick
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    w_rec;
    logic [1:0]    w_ld;

    assign w_rec = {ramBRecord, ramARecord};
    assign w_ld  = {loadBFromRam, loadAFromRam};
    assign tick  = (r_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   r_cnt <= '0;
        else if (tick) r_cnt <= '0;
        else           r_cnt <= r_cnt + CW'(1);
    end

    for (genvar t = 0; t < 2; t++) begin : g_trk
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [AW-1:0]    r_wp;
        logic [AW-1:0]    r_pp;
        logic [AW:0]      r_len;
        logic             r_full;
        logic             r_rec_d;
        logic             r_ld_d;
        logic [WIDTH-1:0] r_play;
        logic [AW-1:0]    w_wp_eff;
        logic [AW-1:0]    w_pp_eff;
        logic [AW:0]      w_wp_inc;
        logic [AW:0]      w_pp_inc;
        logic             w_full_eff;
        logic             w_we;

        // Edge actions are folded in ahead of the tick so a start on a tick lands at entry 0.
        assign w_wp_eff   = (w_rec[t] && !r_rec_d) ? '0 : r_wp;
        assign w_full_eff = (w_rec[t] && !r_rec_d) ? 1'b0 : r_full;
        assign w_pp_eff   = (w_ld[t] && !r_ld_d) ? '0 : r_pp;
        assign w_wp_inc   = {1'b0, w_wp_eff} + (AW+1)'(1);
        assign w_pp_inc   = {1'b0, w_pp_eff} + (AW+1)'(1);
        assign w_we       = w_rec[t] && tick && !w_full_eff;

        always_ff @(posedge clk) begin
            if (w_we) r_mem[w_wp_eff] <= keys_in;
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_wp    <= '0;
                r_pp    <= '0;
                r_len   <= '0;
                r_full  <= 1'b0;
                r_rec_d <= 1'b0;
                r_ld_d  <= 1'b0;
                r_play  <= '0;
            end else begin
                r_rec_d <= w_rec[t];
                r_ld_d  <= w_ld[t];
                if (w_rec[t]) begin
                    r_play <= '0;
                    r_pp   <= '0;
                    if (w_we) begin
                        r_wp   <= w_wp_inc[AW-1:0];
                        r_len  <= w_wp_inc;
                        r_full <= (w_wp_inc == (AW+1)'(DEPTH));
                    end else begin
                        r_wp   <= w_wp_eff;
                        r_len  <= r_rec_d ? r_len : '0;
                        r_full <= w_full_eff;
                    end
                end else if (w_ld[t]) begin
                    if (r_len == '0) begin
                        r_play <= '0;
                        r_pp   <= w_pp_eff;
                    end else if (tick) begin
                        r_play <= r_mem[w_pp_eff];
                        r_pp   <= (w_pp_inc == r_len) ? '0 : w_pp_inc[AW-1:0];
                    end else begin
                        r_pp   <= w_pp_eff;
                    end
                end else begin
                    r_play <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) notes_out <= '0;
        else         notes_out <= keys_in | playA | playB;
    end

    assign playA = g_trk[0].r_play;
    assign playB = g_trk[1].r_play;
    assign lenA  = g_trk[0].r_len;
    assign lenB  = g_trk[1].r_len;
    assign fullA = g_trk[0].r_full;
    assign fullB = g_trk[1].r_full;
endmodule

// File: doc/beat_track_memory.md
# beat_track_memory

Two-track beat storage and playback datapath driven by the record/playback controller's `loadAFromRam`, `loadBFromRam`, `ramARecord` and `ramBRecord` strobes. While a record strobe is high, it samples the live key vector once per beat tick into that track's on-chip memory. While a load strobe is high, it loops the stored track back out, one entry per tick. It also produces the merged note vector (live keys OR track A OR track B) consumed by the audio/tone stage.

## Interface
- `WIDTH`, 4: bits per sample (one per key/voice).
- `DEPTH`, 256: samples per track; power of two, ≥ 2.
- `TICK_DIV`, 50000: clocks per beat tick; ≥ 2.
- `clk` input 1: system clock; all state on rising edge.
- `resetn` input 1: reset, asynchronous, active-low.
- `keys_in` input WIDTH: live key vector, active-high, synchronous to `clk`.
- `ramARecord` input 1: record track A while high.
- `ramBRecord` input 1: record track B while high.
- `loadAFromRam` input 1: play track A while high.
- `loadBFromRam` input 1: play track B while high.
- `playA` output WIDTH: current track-A playback sample.
- `playB` output WIDTH: current track-B playback sample.
- `notes_out` output WIDTH: registered `keys_in | playA | playB`.
- `lenA` output log2(DEPTH)+1: samples stored in track A.
- `lenB` output log2(DEPTH)+1: samples stored in track B.
- `fullA` output 1: track A reached DEPTH during the current or last take.
- `fullB` output 1: track B reached DEPTH during the current or last take.
- `tick` output 1: one-clock beat pulse (debug/LED).

## Operation
- Prescaler: free-running counter 0..TICK_DIV-1. `tick`=1 exactly in the cycle the count equals TICK_DIV-1, then the counter wraps to 0.
- Each track (A, B identical, fully independent) has:
  - memory `DEPTH×WIDTH`,
  - write pointer `wp`,
  - length `len`,
  - play pointer `pp`,
  - flag `full`,
  - registered copies of its record and load strobes for edge detection.
- Record start (record strobe 0→1, detected against the registered copy): `wp`←0, `len`←0, `full`←0 on that edge.
- Recording (record strobe high, `full`=0, `tick`=1): `mem[wp]`←`keys_in`, `wp`←`wp+1`, `len`←`wp+1`. When `len` reaches DEPTH, `full`←1 and further ticks are ignored until the next record start.
- Record stop (strobe 1→0): `len` and `full` hold; memory holds.
- Playback (load strobe high, record strobe low):
  - On the load 0→1 edge, `pp`←0.
  - On each `tick` with `len`≠0: `playX`←`mem[pp]`, and `pp`←(`pp+1`==`len`) ? 0 : `pp+1`.
  - With `len`=0, `playX`←0.
- Load low: `playX`←0 on the next clock; `pp` holds.
- Record and load high on the same track: record wins. `playX` is forced to 0 and `pp` is held at 0. When record drops with load still high, playback starts from entry 0.
- Recording one track while playing the other is legal (overdub).
- `notes_out` is registered every clock from the current `keys_in`, `playA` and `playB` register values.

## Timing
- Reset values: `playA`=`playB`=`notes_out`=0, `lenA`=`lenB`=0, `fullA`=`fullB`=0, `tick`=0. Prescaler, all pointers and edge-detect registers are 0. Memory contents are not cleared.
- Reset mid-take: recording and playback abort immediately. After release, `len`=0, so playback outputs 0 until a new take.
- Write latency: the `keys_in` value present in the `tick` cycle is stored at that edge. `len` is visible the next cycle.
- Playback latency: `playX` changes on the clock edge ending the `tick` cycle and holds for TICK_DIV clocks.
- `notes_out` lags its inputs by one clock. A live key reaches `notes_out` in 1 clock.
- Pointer wrap is at `len`, never at DEPTH, unless `len`=DEPTH.
- A strobe edge and a `tick` in the same cycle: the edge action applies first. A record start with `tick` writes `mem[0]` in that cycle and sets `len`=1.

## Test plan
Parameters for all scenarios: WIDTH=4, DEPTH=8, TICK_DIV=4.
- Reset: drive `resetn`=0 mid-operation -> all outputs 0 within the same cycle, no `clk` edge needed; `lenA`=0 after release.
- Record A for 3 ticks with `keys_in`=1,2,4, then drop `ramARecord`, then raise `loadAFromRam` -> `lenA`=3, `playA` sequence 1,2,4,1,2,4, each value held 4 clocks.
- Record B past capacity (12 ticks, `keys_in`=tick index) -> `fullB`=1 after the 8th tick, `lenB`=8; playback yields 0..7, then wraps to 0.
- Overdub: play A (`lenA`=3) while recording B with `keys_in`=8 for 2 ticks -> `playA` continues uninterrupted, `lenB`=2, `notes_out`=`playA`|8 during the write ticks.
- Record and load both high on A -> `playA`=0 throughout; on record drop, `playA` = new `mem[0]` at the next tick.
- Playback with `lenA`=0 after reset -> `playA` stays 0; `notes_out`=`keys_in` delayed 1 clock.
